// File: rtl/div_ctrl_pkg.sv
// Shared widths, state codes and helpers for the multi-cycle divider.
package div_ctrl_pkg;

  localparam int unsigned reg_w  = 32;
  localparam int unsigned dreg_w = 64;
  localparam int unsigned work_w = 65;
  localparam int unsigned cnt_w  = 6;

  localparam logic div_start          = 1'b1;
  localparam logic div_stop           = 1'b0;
  localparam logic div_result_ready     = 1'b1;
  localparam logic div_result_not_ready = 1'b0;

  typedef enum logic [1:0] {
    div_free    = 2'b00,
    div_by_zero = 2'b01,
    div_on      = 2'b10,
    div_end     = 2'b11
  } div_state_e;

  typedef struct packed {
    logic [reg_w-1:0] rem;
    logic [reg_w-1:0] quot;
  } div_result_t;

  // Magnitude of x; negation only applies to negative signed operands.
  function automatic logic [reg_w-1:0] abs_val(input logic [reg_w-1:0] x, input logic sgn);
    return (sgn && x[reg_w-1]) ? (~x + reg_w'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the 65-bit work register.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [work_w-2:0] work,
  input  logic [reg_w-1:0]  divisor,
  output logic [work_w-1:0] work_nxt
);

  logic [reg_w:0] diff;

  assign diff = {1'b0, work[2*reg_w-1:reg_w]} - {1'b0, divisor};

  // A borrow means the trial subtraction failed: shift in a 0 quotient bit.
  assign work_nxt = diff[reg_w] ? {work, 1'b0}
                                : {diff[reg_w-1:0], work[reg_w-1:0], 1'b1};

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: accepts operands, runs 32 restoring steps, holds the result for HI/LO.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              annul_i,
  input  logic [reg_w-1:0]  opdata1_i,
  input  logic [reg_w-1:0]  opdata2_i,
  output logic [dreg_w-1:0] result_o,
  output logic              ready_o,
  output logic              stallreq_o
);

  div_state_e        state;
  logic [cnt_w-1:0]  cnt;
  logic [work_w-1:0] work;
  logic [work_w-1:0] work_nxt;
  logic [reg_w-1:0]  divisor_abs;
  logic              neg_q;
  logic              neg_r;
  logic [reg_w-1:0]  quot_raw;
  logic [reg_w-1:0]  rem_raw;
  div_result_t       fixed;

  div_step u_step (
    .work     (work[work_w-2:0]),
    .divisor  (divisor_abs),
    .work_nxt (work_nxt)
  );

  // Sign fix-up: quotient by sign mismatch, remainder follows the dividend.
  assign quot_raw   = work[reg_w-1:0];
  assign rem_raw    = work[work_w-1:reg_w+1];
  assign fixed.quot = neg_q ? (~quot_raw + reg_w'(1)) : quot_raw;
  assign fixed.rem  = neg_r ? (~rem_raw + reg_w'(1)) : rem_raw;

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= div_free;
      cnt         <= '0;
      work        <= '0;
      divisor_abs <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result_o    <= '0;
      ready_o     <= div_result_not_ready;
    end else begin
      case (state)
        div_free: begin
          result_o <= '0;
          ready_o  <= div_result_not_ready;
          if (start_i == div_start && !annul_i) begin
            divisor_abs <= abs_val(opdata2_i, signed_i);
            neg_q       <= signed_i & (opdata1_i[reg_w-1] ^ opdata2_i[reg_w-1]);
            neg_r       <= signed_i & opdata1_i[reg_w-1];
            if (opdata2_i == '0) begin
              state <= div_by_zero;
            end else begin
              state <= div_on;
              cnt   <= '0;
              work  <= {reg_w'(0), abs_val(opdata1_i, signed_i), 1'b0};
            end
          end
        end
        div_by_zero: begin
          if (annul_i) begin
            state <= div_free;
          end else begin
            state    <= div_end;
            result_o <= '0;
            ready_o  <= div_result_ready;
          end
        end
        div_on: begin
          if (annul_i) begin
            state <= div_free;
          end else if (cnt != cnt_w'(reg_w)) begin
            work <= work_nxt;
            cnt  <= cnt + cnt_w'(1);
          end else begin
            state    <= div_end;
            result_o <= fixed;
            ready_o  <= div_result_ready;
          end
        end
        div_end: begin
          if (annul_i || start_i == div_stop) begin
            state    <= div_free;
            result_o <= '0;
            ready_o  <= div_result_not_ready;
          end
        end
        default: state <= div_free;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed fix-up, divide-by-zero, annul and reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_cmp = 0;
  int n_bad = 0;

  div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .annul_i    (annul_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one divide with start held, scrambling operands after the accepting edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int exp_lat, input string name);
    int n;
    int stall_bad;
    n = 0;
    stall_bad = 0;
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = sgn;
    start_i   = 1'b1;
    #1;
    while (ready_o !== 1'b1 && n < 100) begin
      if (stallreq_o !== 1'b1) stall_bad++;
      tick();
      n++;
      if (n == 1) begin
        opdata1_i = 32'hDEADBEEF;
        opdata2_i = 32'h0;
        signed_i  = ~sgn;
      end
    end
    n_cmp++;
    if (n - 1 !== exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got edge %0d, expected edge %0d", name, n - 1, exp_lat);
    end
    n_cmp++;
    if (stall_bad !== 0) begin
      n_bad++;
      $display("FAIL %s stall: %0d cycles with stallreq_o low, expected 0", name, stall_bad);
    end
    n_cmp++;
    if (result_o !== exp) begin
      n_bad++;
      $display("FAIL %s result: got %h, expected %h", name, result_o, exp);
    end
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s stall_at_ready: got %b, expected 0", name, stallreq_o);
    end
    tick();
    n_cmp++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      n_bad++;
      $display("FAIL %s hold: got ready %b result %h, expected 1 %h", name, ready_o, result_o, exp);
    end
    start_i = 1'b0;
    tick();
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_bad++;
      $display("FAIL %s release: got ready %b result %h, expected 0 0", name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got ready %b result %h stall %b, expected 0 0 0",
               ready_o, result_o, stallreq_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divu_basic();
    do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, "divu_100_7");
    do_div(32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 33, "divu_fff9_2");
  endtask

  task automatic test_signed();
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, "div_m7_2");
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, "div_7_m2");
  endtask

  task automatic test_by_zero();
    do_div(32'd5, 32'd0, 1'b1, 64'h0, 1, "div_by_zero");
  endtask

  task automatic test_annul();
    int ready_seen;
    ready_seen = 0;
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) begin
      if (ready_o !== 1'b0) ready_seen++;
      tick();
    end
    annul_i = 1'b1;
    #1;
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL annul_stall: got %b, expected 0", stallreq_o);
    end
    tick();
    annul_i = 1'b0;
    if (ready_o !== 1'b0) ready_seen++;
    n_cmp++;
    if (ready_seen !== 0) begin
      n_bad++;
      $display("FAIL annul_ready: ready_o high %0d times, expected 0", ready_seen);
    end
    do_div(32'd9, 32'd4, 1'b0, 64'h00000001_00000002, 33, "after_annul_9_4");
  endtask

  task automatic test_annul_in_free();
    start_i = 1'b1; annul_i = 1'b1;
    opdata1_i = 32'd50; opdata2_i = 32'd0; signed_i = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL annul_free: got ready %b stall %b, expected 0 0", ready_o, stallreq_o);
    end
    annul_i = 1'b0;
    do_div(32'd50, 32'd6, 1'b0, 64'h00000002_00000008, 33, "after_annul_free");
  endtask

  task automatic test_overflow();
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, "div_overflow");
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, "divu_max_1");
  endtask

  task automatic test_reset_mid();
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    tick();
    for (int i = 1; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid: got ready %b result %h stall %b, expected 0 0 1",
               ready_o, result_o, stallreq_o);
    end
    start_i = 1'b0;
    #1;
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_stall: got %b, expected 0", stallreq_o);
    end
    tick();
    do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, "after_reset_mid");
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_by_zero();
    test_annul();
    test_annul_in_free();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
